cpc_bus_cycle_decoder: RTL and testbench

Registered Z80 bus-cycle classifier and RAM-configuration port decoder for the CPC 512K expansion CPLD. It sits directly upstream of the RAM banking/mapping logic. It samples the raw CPC edge-connector strobes on every `clk` rising edge and produces:
- a clean cycle type, start/end pulses and a T-state count;
- a glitch-filtered, once-per-cycle capture of the 0x7Fxx `0b11cccbbb` bank-select write (`ramcfg_q`, `mode3_q`).

The mapping logic consumes these outputs instead of raw combinational decodes.

---
 rtl/cpc_bus_cycle_decoder.sv | 158 +++++++++++++++
 tb/tb_cpc_bus_cycle_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cpc_bus_cycle_decoder.sv
// Registered Z80 bus-cycle classifier and 0x7Fxx RAM-configuration write decoder
// for the CPC 512K expansion; every output comes straight from a register.
module cpc_bus_cycle_decoder #(
    parameter int unsigned IOWR_FILTER = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       mreq_b,
    input  logic       iorq_b,
    input  logic       rd_b,
    input  logic       wr_b,
    input  logic       m1_b,
    input  logic       rfsh_b,
    input  logic       adr15,
    input  logic [7:0] data,
    output logic [2:0] cyc_type,
    output logic       cyc_start,
    output logic       cyc_end,
    output logic [2:0] tstate_cnt,
    output logic [5:0] ramcfg_q,
    output logic       mode3_q,
    output logic       ramcfg_wr
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPFETCH = 3'd1,
        S_MEM_RD  = 3'd2,
        S_MEM_WR  = 3'd3,
        S_REFRESH = 3'd4,
        S_IO_RD   = 3'd5,
        S_IO_WR   = 3'd6,
        S_INTACK  = 3'd7
    } state_t;

    localparam logic [2:0] FILT = 3'(IOWR_FILTER);

    state_t     r_state, w_state_nxt, w_class;
    logic       r_armed, w_armed_nxt;
    logic       r_start, w_start_nxt;
    logic       r_end, w_end_nxt;
    logic [2:0] r_tcnt, w_tcnt_nxt;
    logic [2:0] r_fcnt, w_fcnt_nxt, w_finc;
    logic       r_committed, w_committed_nxt;
    logic [5:0] r_ramcfg, w_ramcfg_nxt;
    logic       r_mode3, w_mode3_nxt;
    logic       r_cfgwr, w_cfgwr_nxt;
    logic       w_is_mem, w_end_cond, w_qual, w_filter_active;

    always_comb begin
        w_class = S_IDLE;
        if (!mreq_b) begin
            if (!rfsh_b)    w_class = S_REFRESH;
            else if (!m1_b) w_class = S_OPFETCH;
            else if (!rd_b) w_class = S_MEM_RD;
            else            w_class = S_MEM_WR;
        end else if (!iorq_b) begin
            if (!m1_b)      w_class = S_INTACK;
            else if (!wr_b) w_class = S_IO_WR;
            else if (!rd_b) w_class = S_IO_RD;
        end
    end

    assign w_is_mem   = (r_state == S_OPFETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR)  || (r_state == S_REFRESH);
    assign w_end_cond = w_is_mem ? mreq_b : iorq_b;
    assign w_qual     = !iorq_b && !wr_b && !adr15 && (data[7:6] == 2'b11);
    assign w_finc     = (r_fcnt == FILT) ? FILT : r_fcnt + 3'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_armed_nxt     = r_armed;
        w_start_nxt     = 1'b0;
        w_end_nxt       = 1'b0;
        w_tcnt_nxt      = r_tcnt;
        w_fcnt_nxt      = r_fcnt;
        w_committed_nxt = r_committed;
        w_ramcfg_nxt    = r_ramcfg;
        w_mode3_nxt     = r_mode3;
        w_cfgwr_nxt     = 1'b0;
        w_filter_active = 1'b0;

        if (r_state == S_IDLE) begin
            w_tcnt_nxt      = 3'd0;
            w_fcnt_nxt      = 3'd0;
            w_committed_nxt = 1'b0;
            if (!r_armed) begin
                w_armed_nxt = mreq_b && iorq_b;
            end else if (w_class != S_IDLE) begin
                w_state_nxt     = w_class;
                w_start_nxt     = 1'b1;
                w_filter_active = (w_class == S_IO_WR);
            end
        end else if (w_end_cond) begin
            w_state_nxt     = S_IDLE;
            w_end_nxt       = 1'b1;
            w_tcnt_nxt      = 3'd0;
            w_fcnt_nxt      = 3'd0;
            w_committed_nxt = 1'b0;
        end else begin
            if (r_tcnt != 3'd7) w_tcnt_nxt = r_tcnt + 3'd1;
            w_filter_active = (r_state == S_IO_WR);
        end

        // The start clock of IO_WR is itself the first filter sample; counter is 0 there.
        if (w_filter_active) begin
            if (w_qual) begin
                w_fcnt_nxt = w_finc;
                if ((w_finc == FILT) && !r_committed) begin
                    w_ramcfg_nxt    = data[5:0];
                    w_mode3_nxt     = (data[2:0] == 3'b011);
                    w_cfgwr_nxt     = 1'b1;
                    w_committed_nxt = 1'b1;
                end
            end else begin
                w_fcnt_nxt = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_armed     <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_tcnt      <= '0;
            r_fcnt      <= '0;
            r_committed <= 1'b0;
            r_ramcfg    <= '0;
            r_mode3     <= 1'b0;
            r_cfgwr     <= 1'b0;
        end else begin
            r_armed     <= w_armed_nxt;
            r_start     <= w_start_nxt;
            r_end       <= w_end_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_committed <= w_committed_nxt;
            r_ramcfg    <= w_ramcfg_nxt;
            r_mode3     <= w_mode3_nxt;
            r_cfgwr     <= w_cfgwr_nxt;
        end
    end

    assign cyc_type   = r_state;
    assign cyc_start  = r_start;
    assign cyc_end    = r_end;
    assign tstate_cnt = r_tcnt;
    assign ramcfg_q   = r_ramcfg;
    assign mode3_q    = r_mode3;
    assign ramcfg_wr  = r_cfgwr;

endmodule

// File: tb/tb_cpc_bus_cycle_decoder.sv
// Directed bench for cpc_bus_cycle_decoder: hand-computed expectations per clock.
module tb_cpc_bus_cycle_decoder;

    logic       clk = 1'b0;
    logic       reset_b, mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, adr15;
    logic [7:0] data;
    logic [2:0] cyc_type, tstate_cnt;
    logic       cyc_start, cyc_end, mode3_q, ramcfg_wr;
    logic [5:0] ramcfg_q;

    int checks = 0;
    int errors = 0;
    int end_pulses;

    cpc_bus_cycle_decoder #(.IOWR_FILTER(2)) dut (
        .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .iorq_b(iorq_b),
        .rd_b(rd_b), .wr_b(wr_b), .m1_b(m1_b), .rfsh_b(rfsh_b), .adr15(adr15),
        .data(data), .cyc_type(cyc_type), .cyc_start(cyc_start), .cyc_end(cyc_end),
        .tstate_cnt(tstate_cnt), .ramcfg_q(ramcfg_q), .mode3_q(mode3_q),
        .ramcfg_wr(ramcfg_wr)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [2:0] t, input logic s,
                           input logic e, input logic [2:0] tc);
        chk({tag, " type"}, 8'(cyc_type), 8'(t));
        chk({tag, " start"}, 8'(cyc_start), 8'(s));
        chk({tag, " end"}, 8'(cyc_end), 8'(e));
        chk({tag, " tstate"}, 8'(tstate_cnt), 8'(tc));
    endtask

    task automatic chk_cfg(input string tag, input logic [5:0] q, input logic m, input logic w);
        chk({tag, " ramcfg_q"}, 8'(ramcfg_q), 8'(q));
        chk({tag, " mode3"}, 8'(mode3_q), 8'(m));
        chk({tag, " ramcfg_wr"}, 8'(ramcfg_wr), 8'(w));
    endtask

    task automatic idle_bus();
        mreq_b = 1; iorq_b = 1; rd_b = 1; wr_b = 1; m1_b = 1; rfsh_b = 1;
        adr15 = 0;
    endtask

    initial begin
        idle_bus();
        data = 8'h00;
        reset_b = 0;
        mreq_b = 0;
        tick(); tick();
        chk_cyc("reset", 3'd0, 0, 0, 3'd0);
        chk_cfg("reset", 6'h00, 0, 0);

        // Cycle already in progress at reset release must be ignored.
        reset_b = 1; m1_b = 0;
        tick(); tick();
        chk_cyc("unarmed", 3'd0, 0, 0, 3'd0);
        idle_bus();
        tick();
        chk_cyc("arming", 3'd0, 0, 0, 3'd0);

        mreq_b = 0; m1_b = 0;
        tick(); chk_cyc("fetch t0", 3'd1, 1, 0, 3'd0);
        tick(); chk_cyc("fetch t1", 3'd1, 0, 0, 3'd1);
        idle_bus();
        tick(); chk_cyc("fetch end", 3'd0, 0, 1, 3'd0);
        mreq_b = 0; rfsh_b = 0;
        tick(); chk_cyc("rfsh t0", 3'd4, 1, 0, 3'd0);
        tick(); chk_cyc("rfsh t1", 3'd4, 0, 0, 3'd1);
        idle_bus();
        tick(); chk_cyc("rfsh end", 3'd0, 0, 1, 3'd0);

        // OUT &7F00,&C7
        iorq_b = 0; wr_b = 0; data = 8'hC7;
        tick(); chk_cyc("out c7 t0", 3'd6, 1, 0, 3'd0); chk_cfg("out c7 t0", 6'h00, 0, 0);
        tick(); chk_cfg("out c7 t1", 6'h07, 0, 1);
        tick(); chk_cfg("out c7 t2", 6'h07, 0, 0);
        idle_bus();
        tick(); chk_cyc("out c7 end", 3'd0, 0, 1, 3'd0);

        iorq_b = 0; wr_b = 0; data = 8'hC3;
        tick(); chk_cfg("out c3 t0", 6'h07, 0, 0);
        tick(); chk_cfg("out c3 t1", 6'h03, 1, 1);
        tick(); chk_cfg("out c3 t2", 6'h03, 1, 0);
        idle_bus();
        tick(); chk_cyc("out c3 end", 3'd0, 0, 1, 3'd0);

        // One-clock glitch never reaches the filter threshold.
        iorq_b = 0; wr_b = 0; data = 8'hC4;
        tick(); chk_cyc("glitch t0", 3'd6, 1, 0, 3'd0); chk_cfg("glitch t0", 6'h03, 1, 0);
        idle_bus();
        tick(); chk_cfg("glitch end", 6'h03, 1, 0);

        iorq_b = 0; wr_b = 0; adr15 = 1; data = 8'hC4;
        tick(); tick(); chk_cfg("adr15 t1", 6'h03, 1, 0);
        tick(); chk_cfg("adr15 t2", 6'h03, 1, 0);
        idle_bus();
        tick(); chk_cyc("adr15 end", 3'd0, 0, 1, 3'd0);

        iorq_b = 0; wr_b = 0; data = 8'h84;
        tick(); tick(); chk_cfg("d84 t1", 6'h03, 1, 0);
        tick(); chk_cfg("d84 t2", 6'h03, 1, 0);
        idle_bus();
        tick(); chk_cfg("d84 end", 6'h03, 1, 0);

        // IO with neither rd nor wr waits in IDLE, then classifies.
        iorq_b = 0;
        tick(); chk_cyc("io retry", 3'd0, 0, 0, 3'd0);
        rd_b = 0;
        tick(); chk_cyc("io rd t0", 3'd5, 1, 0, 3'd0);
        idle_bus();
        tick(); chk_cyc("io rd end", 3'd0, 0, 1, 3'd0);

        iorq_b = 0; m1_b = 0;
        tick(); chk_cyc("intack t0", 3'd7, 1, 0, 3'd0);
        idle_bus();
        tick(); chk_cyc("intack end", 3'd0, 0, 1, 3'd0);

        // Both strobes low: memory classification wins; IO release does not end it.
        mreq_b = 0; iorq_b = 0; rd_b = 0;
        tick(); chk_cyc("both t0", 3'd2, 1, 0, 3'd0);
        iorq_b = 1;
        tick(); chk_cyc("both t1", 3'd2, 0, 0, 3'd1);
        idle_bus();
        tick(); chk_cyc("both end", 3'd0, 0, 1, 3'd0);

        // Wait-stated MEM_WR: late wr_b and a stray rd_b must not reclassify.
        mreq_b = 0;
        tick(); chk_cyc("memwr t0", 3'd3, 1, 0, 3'd0);
        wr_b = 0;
        end_pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) rd_b = 0;
            tick();
            chk_cyc($sformatf("memwr t%0d", k), 3'd3, 0, 0, (k > 7) ? 3'd7 : 3'(k));
            if (cyc_end) end_pulses++;
        end
        idle_bus();
        tick(); chk_cyc("memwr end", 3'd0, 0, 1, 3'd0);
        if (cyc_end) end_pulses++;
        tick(); chk_cyc("memwr post", 3'd0, 0, 0, 3'd0);
        if (cyc_end) end_pulses++;
        chk("memwr end count", 8'(end_pulses), 8'd1);

        // Reset mid IO_WR after commit of &CA.
        iorq_b = 0; wr_b = 0; data = 8'hCA;
        tick(); chk_cyc("out ca t0", 3'd6, 1, 0, 3'd0);
        tick(); chk_cfg("out ca t1", 6'h0A, 0, 1);
        reset_b = 0;
        tick(); chk_cyc("mid reset", 3'd0, 0, 0, 3'd0); chk_cfg("mid reset", 6'h00, 0, 0);
        reset_b = 1;
        tick(); chk_cyc("post reset t0", 3'd0, 0, 0, 3'd0);
        tick(); chk_cfg("post reset t1", 6'h00, 0, 0);
        tick(); chk_cyc("post reset t2", 3'd0, 0, 0, 3'd0); chk_cfg("post reset t2", 6'h00, 0, 0);
        idle_bus();
        tick(); chk_cyc("rearm", 3'd0, 0, 0, 3'd0);
        iorq_b = 0; wr_b = 0;
        tick(); chk_cyc("rearm io wr", 3'd6, 1, 0, 3'd0);
        tick(); chk_cfg("rearm commit", 6'h0A, 0, 1);
        idle_bus();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
